write_pointer_ctrl: RTL and testbench
=====================================

WRITE_POINTER_CTRL -- requirements
Module: write_pointer_ctrl

Interface
REQ-001 The block SHALL have parameter DATADEPTH, default 16: number of FIFO entries, power of two, minimum 4.
REQ-002 The block SHALL define ADDRW = $clog2(DATADEPTH) as the pointer width.
REQ-003 The block SHALL have port w_clk, input, 1 bit: write-domain clock; all state updates on its rising edge.
REQ-004 The block SHALL have port w_rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port w_en, input, 1 bit: write request from the producer.
REQ-006 The block SHALL have port G_R_address, input, ADDRW bits: Gray-coded read pointer, raw from the read clock domain.
REQ-007 The block SHALL have port direction, input, 1 bit: quadrant flag from the direction block, asynchronous to w_clk.
REQ-008 The block SHALL have port G_W_address, output, ADDRW bits: registered Gray-coded write pointer, sent to the direction block and the read domain.
REQ-009 The block SHALL have port W_address, output, ADDRW bits: registered binary write address to the FIFO memory.
REQ-010 The block SHALL have port w_mem_en, output, 1 bit: memory write strobe, combinational.
REQ-011 The block SHALL have port full, output, 1 bit: registered FIFO-full flag.
REQ-012 The block SHALL have port w_ovf, output, 1 bit: sticky overflow flag.

Function
REQ-013 The block SHALL compute w_inc = w_en & ~full, and w_mem_en SHALL equal w_inc.
REQ-014 The block SHALL update W_address to W_address + w_inc modulo DATADEPTH on each w_clk edge; DATADEPTH-1 wraps to 0.
REQ-015 The block SHALL register G_W_address as gray(bin_next), with gray(x) = x ^ (x >> 1), in the same edge as W_address, so the two always encode the same value.
REQ-016 The block SHALL pass G_R_address through a two-flop synchronizer clocked by w_clk to produce rptr_sync; no logic SHALL sit between the two flops.
REQ-017 The block SHALL pass direction through a separate two-flop synchronizer to produce dir_sync.
REQ-018 The block SHALL register full_next = (gray(bin_next) == rptr_sync) & dir_sync each cycle.
REQ-019 Full SHALL assert on the same edge that accepts the write filling the last free entry, provided rptr_sync and dir_sync are already settled; there SHALL be no extra latency.
REQ-020 Full SHALL deassert no earlier than 2 and no later than 3 w_clk edges after G_R_address advances away from G_W_address. This is a pessimistic release.
REQ-021 When w_en = 1 and full = 1: no pointer change, w_mem_en = 0, and w_ovf SHALL set on that edge and stay set until reset.
REQ-022 When w_en = 0: pointers hold, and full is still re-evaluated every cycle.
REQ-023 A read-pointer change and a write in the same cycle SHALL be handled independently: the write uses the current full, and full_next uses the post-write pointer.
REQ-024 The block SHALL NOT produce a Gray pointer transition of more than one bit per edge, including across the wrap.

Reset
REQ-025 While w_rst = 0, the following SHALL be 0 immediately, independent of w_clk: W_address, G_W_address, full, w_ovf, both rptr_sync flops, and both dir_sync flops.
REQ-026 Reset asserted mid-write SHALL discard the write, and w_mem_en SHALL be 0 during reset.
REQ-027 After w_rst deasserts, the first write SHALL be accepted on the first w_clk rising edge with w_en = 1.

Verification (DATADEPTH=16, ADDRW=4)
REQ-028 Reset check: assert w_rst=0 mid-run with W_address=5 -> all outputs 0 within the same timestep, no clock required.
REQ-029 Fill test: G_R_address=0, direction=1, 16 consecutive writes -> W_address steps 0..15 then 0; G_W_address ends at 0000 (gray of 15 is 1000); full=1 on the 16th write edge; w_mem_en=0 afterward.
REQ-030 Overflow test: while full=1, pulse w_en for 3 cycles -> W_address unchanged, w_ovf=1 and remains 1 after w_en drops.
REQ-031 Drain release: from full, set G_R_address=0001 and direction=0 -> full=0 within 2-3 edges; next w_en=1 is accepted with W_address=0 and G_W_address -> 0001.
REQ-032 Wrap/Gray check: 40 writes with reader tracking -> each G_W_address change has Hamming distance 1, and it equals gray(W_address) every cycle.
REQ-033 Simultaneous events: a write of the last entry on the same edge G_R_address advances -> full=1 for that edge (stale sync), then clears within 3 edges; no pointer corruption.

Source files
------------

// File: rtl/write_pointer_ctrl_if.sv
// write_pointer_ctrl_if: write-side FIFO pointer bus between producer/read domain (master) and write_pointer_ctrl (slave)
// w_en, G_R_address, direction : driven by master
// G_W_address, W_address, w_mem_en, full, w_ovf : driven by slave
interface write_pointer_ctrl_if #(parameter int ADDRW = 4);
  logic             w_en;
  logic [ADDRW-1:0] G_R_address;
  logic             direction;
  logic [ADDRW-1:0] G_W_address;
  logic [ADDRW-1:0] W_address;
  logic             w_mem_en;
  logic             full;
  logic             w_ovf;
  modport master (output w_en, G_R_address, direction, input G_W_address, W_address, w_mem_en, full, w_ovf);
  modport slave (input w_en, G_R_address, direction, output G_W_address, W_address, w_mem_en, full, w_ovf);
endinterface

// File: rtl/write_pointer_ctrl.sv
// write_pointer_ctrl: async-FIFO write pointer, Gray encoding, read-pointer/direction sync and full/overflow flags
// w_clk : write-domain clock
// w_rst : asynchronous active-low reset
// bus   : slave side of write_pointer_ctrl_if (w_en, G_R_address, direction in; G_W_address, W_address, w_mem_en, full, w_ovf out)
module write_pointer_ctrl #(
  parameter int DATADEPTH = 16
) (
  input logic                 w_clk,
  input logic                 w_rst,
  write_pointer_ctrl_if.slave bus
);
  localparam int ADDRW = $clog2(DATADEPTH);
  logic [ADDRW-1:0] bin_q, bin_d, gray_q, gray_d, rs1_q, rs2_q;
  logic             ds1_q, ds2_q, full_q, full_d, ovf_q, ovf_d, inc;
  // w_rst gating keeps the memory strobe low while reset is held
  always_comb begin
    inc    = bus.w_en & ~full_q & w_rst;
    bin_d  = bin_q + ADDRW'(inc);
    gray_d = bin_d ^ (bin_d >> 1);
    full_d = (gray_d == rs2_q) & ds2_q;
    ovf_d  = ovf_q | (bus.w_en & full_q);
  end
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      ds1_q  <= 1'b0;
      ds2_q  <= 1'b0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      rs1_q  <= bus.G_R_address;
      rs2_q  <= rs1_q;
      ds1_q  <= bus.direction;
      ds2_q  <= ds1_q;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end
  assign bus.W_address   = bin_q;
  assign bus.G_W_address = gray_q;
  assign bus.w_mem_en    = inc;
  assign bus.full        = full_q;
  assign bus.w_ovf       = ovf_q;
endmodule

// File: tb/tb_write_pointer_ctrl.sv
// tb_write_pointer_ctrl: self-checking bench for write_pointer_ctrl (DATADEPTH=16)
module tb_write_pointer_ctrl;
  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  always #5 w_clk = ~w_clk;
  write_pointer_ctrl_if #(.ADDRW(4)) bus ();
  write_pointer_ctrl #(.DATADEPTH(16)) dut (.w_clk(w_clk), .w_rst(w_rst), .bus(bus));
  typedef struct {
    logic       en;
    logic [3:0] gra;
    logic       dir;
    logic       men;
    logic [3:0] w;
    logic [3:0] g;
    logic       full;
    logic       ovf;
  } vec_t;
  typedef struct {
    logic [3:0] w;
    logic [3:0] g;
    logic       full;
    logic       ovf;
  } exp_t;
  vec_t tbl[20];
  exp_t sb[$];
  function automatic logic [3:0] gray(input logic [3:0] x);
    return x ^ (x >> 1);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic do_reset();
    w_rst = 1'b0;
    bus.w_en = 1'b0;
    bus.G_R_address = 4'd0;
    bus.direction = 1'b0;
    @(negedge w_clk);
    w_rst = 1'b1;
  endtask
  task automatic apply(input vec_t v, input int idx);
    exp_t e, a;
    bus.w_en = v.en;
    bus.G_R_address = v.gra;
    bus.direction = v.dir;
    #1;
    chk($sformatf("vec%0d_w_mem_en", idx), bus.w_mem_en, v.men);
    e = '{v.w, v.g, v.full, v.ovf};
    sb.push_back(e);
    @(posedge w_clk);
    #1;
    a = sb.pop_front();
    chk($sformatf("vec%0d_W_address", idx), bus.W_address, a.w);
    chk($sformatf("vec%0d_G_W_address", idx), bus.G_W_address, a.g);
    chk($sformatf("vec%0d_full", idx), bus.full, a.full);
    chk($sformatf("vec%0d_w_ovf", idx), bus.w_ovf, a.ovf);
  endtask
  task automatic writes(input int n);
    bus.w_en = 1'b1;
    repeat (n) begin
      @(posedge w_clk);
      #1;
    end
    bus.w_en = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] expw, prevg;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 4'd0, logic'(i >= 8), 1'b1, 4'(i + 1), gray(4'(i + 1)), logic'(i == 15), 1'b0};
    for (int i = 16; i < 19; i++) tbl[i] = '{1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1};
    bus.w_en = 1'b1;
    bus.G_R_address = 4'd0;
    bus.direction = 1'b0;
    #1 w_rst = 1'b0;
    #1;
    chk("rst_W_address", bus.W_address, 4'd0);
    chk("rst_G_W_address", bus.G_W_address, 4'd0);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_w_ovf", bus.w_ovf, 1'b0);
    chk("rst_w_mem_en", bus.w_mem_en, 1'b0);
    @(negedge w_clk);
    w_rst = 1'b1;
    for (int i = 0; i < 20; i++) apply(tbl[i], i);
    bus.w_en = 1'b0;
    bus.G_R_address = 4'd1;
    bus.direction = 1'b0;
    @(posedge w_clk);
    #1 chk("drain_edge1_full", bus.full, 1'b1);
    @(posedge w_clk);
    @(posedge w_clk);
    #1 chk("drain_edge3_full", bus.full, 1'b0);
    bus.w_en = 1'b1;
    #1 chk("drain_w_mem_en", bus.w_mem_en, 1'b1);
    @(posedge w_clk);
    #1;
    bus.w_en = 1'b0;
    chk("drain_W_address", bus.W_address, 4'd1);
    chk("drain_G_W_address", bus.G_W_address, 4'd1);
    chk("drain_full", bus.full, 1'b0);
    writes(4);
    chk("pre_reset_W_address", bus.W_address, 4'd5);
    #2;
    bus.w_en = 1'b1;
    w_rst = 1'b0;
    #1;
    chk("midrst_W_address", bus.W_address, 4'd0);
    chk("midrst_G_W_address", bus.G_W_address, 4'd0);
    chk("midrst_full", bus.full, 1'b0);
    chk("midrst_w_ovf", bus.w_ovf, 1'b0);
    chk("midrst_w_mem_en", bus.w_mem_en, 1'b0);
    do_reset();
    expw = 4'd0;
    prevg = 4'd0;
    for (int k = 0; k < 40; k++) begin
      bus.w_en = 1'b1;
      @(posedge w_clk);
      #1;
      expw = expw + 4'd1;
      chk($sformatf("wrap%0d_W_address", k), bus.W_address, expw);
      chk($sformatf("wrap%0d_G_W_address", k), bus.G_W_address, gray(expw));
      chk($sformatf("wrap%0d_hamming", k), $countones(bus.G_W_address ^ prevg), 1);
      prevg = bus.G_W_address;
      bus.G_R_address = bus.G_W_address;
    end
    bus.w_en = 1'b0;
    chk("wrap_full", bus.full, 1'b0);
    do_reset();
    writes(15);
    bus.direction = 1'b1;
    repeat (3) @(posedge w_clk);
    #1;
    chk("sim_pre_W_address", bus.W_address, 4'd15);
    chk("sim_pre_full", bus.full, 1'b0);
    bus.G_R_address = 4'd1;
    bus.w_en = 1'b1;
    #1 chk("sim_w_mem_en", bus.w_mem_en, 1'b1);
    @(posedge w_clk);
    #1;
    bus.w_en = 1'b0;
    chk("sim_stale_full", bus.full, 1'b1);
    chk("sim_W_address", bus.W_address, 4'd0);
    for (int e = 0; e < 3 && bus.full; e++) begin
      @(posedge w_clk);
      #1;
    end
    chk("sim_release_full", bus.full, 1'b0);
    chk("sim_final_W_address", bus.W_address, 4'd0);
    chk("sim_final_G_W_address", bus.G_W_address, 4'd0);
    chk("sim_w_ovf", bus.w_ovf, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
